// File: rtl/imem_loader.sv
// Boot loader: length header + little-endian payload into instruction memory, CPU held in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module imem_loader #(
    parameter int unsigned ARCH            = 32,
    parameter int unsigned IMEM_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       byte_valid_in,
    input  logic [7:0]                 byte_data_in,
    output logic                       byte_ready_out,
    input  logic                       restart_in,
    output logic                       imem_we_out,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_out,
    output logic [ARCH-1:0]            imem_data_out,
    output logic                       cpu_rst_n_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic                       error_out
);
    localparam int unsigned MAX_WORDS = 2 ** (IMEM_ADDR_WIDTH - 2);
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned WIDX_W    = IMEM_ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_e;

    state_e                     state_q, state_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           word_idx_q, word_idx_d;
    logic [1:0]                 byte_idx_q, byte_idx_d;
    logic [23:0]                word_q, word_d;
    logic                       we_q, we_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ARCH-1:0]            data_q, data_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 xor_q, xor_d;
`endif

    logic             accept_c;
    logic [LEN_W-1:0] hdr_len_c;

    assign accept_c  = byte_valid_in && ready_q;
    assign hdr_len_c = {byte_data_in, len_q[7:0]};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif

        case (state_q)
            S_LEN_LO: begin
                if (accept_c) begin
                    len_d   = {8'h00, byte_data_in};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept_c) begin
                    len_d = hdr_len_c;
                    if (hdr_len_c > LEN_W'(MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else if (hdr_len_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Reached only after the final write pulse; trailing bytes are dropped
                if (word_idx_q == len_q) begin
                    state_d = S_DONE;
                end else if (accept_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ byte_data_in;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = byte_data_in;
                        2'd1: word_d[15:8]  = byte_data_in;
                        2'd2: word_d[23:16] = byte_data_in;
                        default: begin
                            we_d       = 1'b1;
                            addr_d     = {word_idx_q[WIDX_W-1:0], 2'b00};
                            data_d     = ARCH'({byte_data_in, word_q});
                            word_idx_d = word_idx_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            if (word_idx_q + 16'd1 == len_q) begin
                                state_d = S_CSUM;
                            end
`endif
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_c) begin
                    state_d = (byte_data_in == xor_d) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (restart_in) begin
                    state_d    = S_LEN_LO;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            default: state_d = S_LEN_LO;
        endcase

        busy_d      = (state_d != S_DONE) && (state_d != S_ERROR);
        ready_d     = busy_d;
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_ERROR);
        cpu_rst_n_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN_LO;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign byte_ready_out = ready_q;
    assign imem_we_out    = we_q;
    assign imem_addr_out  = addr_q;
    assign imem_data_out  = data_q;
    assign cpu_rst_n_out  = cpu_rst_n_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign error_out      = err_q;

endmodule
